// File: rtl/fdivsqrt_otfc_seq_pkg.sv
// Shared types for the sequential on-the-fly converter wrapper.
package fdivsqrt_otfc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsm_state_t;

endpackage

// File: rtl/fdivsqrt_otfc_seq_uotfc2.sv
// Radix-2 unified on-the-fly converter: next U/UM from the current digit and position.
module fdivsqrtuotfc2 #(
  parameter int DIVb = 52
) (
  input  logic          up,
  input  logic          un,
  input  logic [DIVb:0] C,
  input  logic [DIVb:0] U,
  input  logic [DIVb:0] UM,
  output logic [DIVb:0] UNext,
  output logic [DIVb:0] UMNext
);

  logic [DIVb:0] k;

  always_comb begin
    // One-hot weight of the digit being appended: lowest set bit of the thermometer.
    k      = C & ~(C << 1);
    UNext  = U;
    UMNext = UM | k;
    if (up) begin
      UNext  = U | k;
      UMNext = U;
    end else if (un) begin
      UNext  = UM | k;
      UMNext = UM;
    end
  end

endmodule

// File: rtl/fdivsqrt_otfc_seq.sv
// Sequential wrapper: FSM, iteration counter and position shifter around the OTFC.
module fdivsqrt_otfc_seq
  import fdivsqrt_otfc_seq_pkg::*;
#(
  parameter int DIVb = 52
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          start,
  input  logic          sqrt,
  input  logic          up,
  input  logic          un,
  input  logic          hold,
  input  logic          abort,
  input  logic          ack,
  output logic          busy,
  output logic          done,
  output logic [DIVb:0]   U,
  output logic [DIVb:0]   UM,
  output logic [DIVb+1:0] C
);

  localparam int CNTW = $clog2(DIVb + 1);

  localparam logic [DIVb+1:0] C_DIV  = {2'b11, {DIVb{1'b0}}};
  localparam logic [DIVb+1:0] C_SQRT = {3'b111, {(DIVb - 1){1'b0}}};
  localparam logic [DIVb:0]   U_SQRT = {1'b1, {DIVb{1'b0}}};

  fsm_state_t      state, state_n;
  logic [CNTW-1:0] cnt;
  logic            load, step;
  logic [DIVb:0]   unext, umnext;

  fdivsqrtuotfc2 #(.DIVb(DIVb)) u_otfc (
    .up    (up),
    .un    (un),
    .C     (C[DIVb:0]),
    .U     (U),
    .UM    (UM),
    .UNext (unext),
    .UMNext(umnext)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_n = IDLE;
        end else if (!hold) begin
          step = 1'b1;
          if (cnt == '0) state_n = DONE;
        end
      end
      DONE: begin
        if (abort) begin
          state_n = IDLE;
        end else if (ack) begin
          if (start) begin
            load    = 1'b1;
            state_n = RUN;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      U   <= '0;
      UM  <= '0;
      C   <= '0;
      cnt <= '0;
    end else if (load) begin
      U   <= sqrt ? U_SQRT : '0;
      UM  <= '0;
      C   <= sqrt ? C_SQRT : C_DIV;
      cnt <= sqrt ? CNTW'(DIVb - 1) : CNTW'(DIVb);
    end else if (step) begin
      U   <= unext;
      UM  <= umnext;
      C   <= {1'b1, C[DIVb+1:1]};
      cnt <= cnt - CNTW'(1);
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule
